uart_tx_fifo: RTL and testbench

- Serial transmit stage sitting directly downstream of the CPU's I/O write path inside riscv_top; drives the top-level Tx pin.
- Buffers bytes written by the core's memory-mapped I/O port in a small FIFO.
- Serialises each byte as 8N1 UART: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Exposes full/empty/busy so the core can stall I/O stores.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit/receive
//                blocks (FSM state encoding, data width, default bit timing).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Count-based single-clock FIFO with show-ahead read data.
//                Writes while full are dropped and flagged on wr_drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              wr_drop
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    // Full/empty depend only on the stored count, so a same-cycle pop never
    // frees room for a write.
    assign full    = (r_count == (ADDR_W+1)'(c_DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = wr_en & ~full;
    assign w_pop   = rd_en & ~empty;
    assign wr_drop = wr_en & full;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO followed by an 8N1 UART serialiser. The line
//                output is registered; consecutive frames run back to back.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_ADDR_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,        // asynchronous, active-low
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   overflow,
    output logic                   tx
);

    localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_t            r_state;
    logic [15:0]            r_bcnt;
    logic [2:0]             r_bidx;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_tx;
    logic                   r_overflow;
    logic [UART_DATA_W-1:0] w_head;
    logic [FIFO_ADDR_W:0]   w_count;
    logic                   w_drop;
    logic                   w_bit_done;
    logic                   w_pop;

    assign w_bit_done = (r_bcnt == c_BIT_LAST);
    // Load the next byte either from idle or exactly at the end of a stop bit.
    assign w_pop      = ~empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_done));
    assign busy       = (r_state != IDLE) | (w_count != '0);
    assign overflow   = r_overflow;
    assign tx         = r_tx;

    sync_fifo #(
        .WIDTH  (UART_DATA_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (full),
        .empty   (empty),
        .count   (w_count),
        .wr_drop (w_drop)
    );

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_overflow <= 1'b0;
        else      r_overflow <= r_overflow | w_drop;
    end

    // Framing FSM: the line level is computed for the next state so tx changes
    // on the same edge as the state and each level lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_bcnt  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_bcnt  <= '0;
                        r_bidx  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_bcnt  <= r_bcnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_bcnt  <= '0;
                        r_shift <= r_shift >> 1;
                        r_bidx  <= r_bidx + 3'd1;
                        if (r_bidx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_bcnt  <= r_bcnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_bcnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo: frame-position model of
//                the line, a line decoder, and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, overflow, tx;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_ADDR_W  (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue + position within frame -----
    byte unsigned mq[$];
    byte unsigned acc[$];
    int           pos = -1;
    logic [7:0]   cur = 8'h00;
    logic         m_ovf = 1'b0;
    int           m_sz;
    bit           m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            acc.delete();
            pos   = -1;
            m_ovf = 1'b0;
        end else begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && (pos < 0 || pos == FRAME - 1);
            if (m_pop) begin
                cur = mq.pop_front();
                pos = 0;
            end else if (pos >= 0) begin
                pos++;
                if (pos == FRAME) pos = -1;
            end
            if (wr_en) begin
                if (m_sz < DEPTH) begin
                    mq.push_back(wr_data);
                    acc.push_back(wr_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic model_tx();
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur[k-1];
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_tx",       tx,       model_tx());
        check("m_full",     full,     mq.size() == DEPTH);
        check("m_empty",    empty,    mq.size() == 0);
        check("m_busy",     busy,     (pos >= 0) || (mq.size() != 0));
        check("m_overflow", overflow, m_ovf);
    end

    // ---------------- line decoder ----------------------------------------
    byte unsigned rx[$];
    int           dpos = -1;
    logic [7:0]   dbyte = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            dpos = -1;
        end else if (dpos < 0) begin
            if (tx == 1'b0) dpos = 0;
        end else begin
            dpos++;
            if (dpos % CPB == CPB / 2 && dpos / CPB >= 1 && dpos / CPB <= 8)
                dbyte[dpos/CPB-1] = tx;
            if (dpos == 9 * CPB + CPB / 2) check("stop_bit", tx, 1'b1);
            if (dpos == FRAME - 1) begin
                rx.push_back(dbyte);
                dpos = -1;
            end
        end
    end

    task automatic wait_idle(input int max_cycles);
        int c = 0;
        while (busy && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check("drain_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rx_vs_acc(input string name);
        check({name, "_cnt"}, rx.size(), acc.size());
        for (int i = 0; i < acc.size(); i++) check({name, "_byte"}, rx[i], acc[i]);
    endtask

    logic [9:0] lvl_a5;
    logic [7:0] bdat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_empty", empty, 1'b1);
            check("idle_full", full, 1'b0);
            check("idle_ovf", overflow, 1'b0);
        end

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
        lvl_a5 = 10'b1_10100101_0;
        wr_en = 1'b1; wr_data = 8'hA5;
        for (int j = 0; j <= 44; j++) begin
            @(negedge clk);
            if (j == 0) wr_en = 1'b0;
            check("a5_tx", tx, (j >= 1 && j <= 40) ? lvl_a5[(j-1)/CPB] : 1'b1);
            if (j == 40) check("a5_busy_hold", busy, 1'b1);
            if (j == 41) check("a5_busy_fall", busy, 1'b0);
        end
        check("a5_rx_cnt", rx.size(), 1);
        check("a5_rx", rx[0], 8'hA5);
        rx.delete(); acc.delete();

        // Back-to-back 0x00, 0xFF
        wr_en = 1'b1; wr_data = 8'h00;
        @(negedge clk);
        wr_data = 8'hFF;
        for (int j = 1; j <= 85; j++) begin
            @(negedge clk);
            if (j == 1) wr_en = 1'b0;
            if (j == 40) check("b2b_stop1", tx, 1'b1);
            if (j == 41) check("b2b_start2", tx, 1'b0);
            if (j == 45) check("b2b_data2", tx, 1'b1);
            if (j == 81) check("b2b_idle", tx, 1'b1);
        end
        check("b2b_rx_cnt", rx.size(), 2);
        check("b2b_rx0", rx[0], 8'h00);
        check("b2b_rx1", rx[1], 8'hFF);
        rx.delete(); acc.delete();

        // Full / overflow: 10 consecutive writes, 0x0A is dropped
        wr_en = 1'b1; wr_data = 8'h01;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            wr_data = 8'(i);
            if (i == 3)  check("ovf_first_pop", tx, 1'b0);
            if (i == 9)  check("ovf_not_full", full, 1'b0);
            if (i == 10) check("ovf_full", full, 1'b1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_flag", overflow, 1'b1);
        wait_idle(600);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_rx_cnt", rx.size(), 9);
        for (int i = 0; i < 9; i++) check("ovf_rx", rx[i], i + 1);
        check_rx_vs_acc("ovf_acc");
        rx.delete(); acc.delete();

        // Wrap-around: 4 bursts of 5 bytes
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                wr_en = 1'b1; wr_data = 8'(8'h40 + b * 5 + i);
                @(negedge clk);
            end
            wr_en = 1'b0;
            wait_idle(400);
        end
        check("wrap_rx_cnt", rx.size(), 20);
        for (int i = 0; i < 20; i++) check("wrap_rx", rx[i], 8'h40 + i);
        check_rx_vs_acc("wrap_acc");
        rx.delete(); acc.delete();

        // Reset mid-frame of 0x3C, during data bit 3 and then data bit 0
        for (int t = 0; t < 2; t++) begin
            bdat = 8'h3C;
            wr_en = 1'b1; wr_data = bdat;
            for (int j = 0; j <= (t == 0 ? 18 : 6); j++) begin
                @(negedge clk);
                if (j == 0) wr_en = 1'b0;
            end
            check("rst_pre_tx", tx, bdat[t == 0 ? 3 : 0]);
            #2 rst = 1'b0;
            #1;
            check("rst_async_tx", tx, 1'b1);
            check("rst_async_empty", empty, 1'b1);
            check("rst_async_busy", busy, 1'b0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (100) @(negedge clk);
            check("rst_after_empty", empty, 1'b1);
            check("rst_after_ovf", overflow, 1'b0);
            check("rst_no_residual", rx.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
